ram1_bus_arbiter: RTL and testbench

- Sequences and shares the single RAM1/UART bus (through the ram1 access block) between two requesters: the instruction-fetch port (IF) and the data-memory port (MEM).
- Decodes the address into RAM1 or UART, issues one-cycle bus commands to ram1, captures ram1res, and returns data with an ack.
- Raises stall toward the pipeline while a requester waits.
- Sits between the CPU pipeline and ram1.

---
 rtl/ram1_bus_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ram1_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram1_bus_arbiter.sv
// ram1_bus_arbiter
//   Shares the single RAM1/UART bus (driven through the ram1 access block)
//   between the instruction-fetch port (IF, read only) and the data-memory
//   port (MEM, read/write). Each granted request takes three states:
//     IDLE    - arbitrate, register the winner's address/data/we
//     ISSUE   - exactly one cycle of bus command toward ram1
//     CAPTURE - bus idle, read data already latched, ack pulses
//   so two ram1 commands are always separated by at least one idle cycle.
//   MEM has priority. IF wins once after STARVE_MAX consecutive MEM grants
//   that it sat through.
//
// Optional feature (macro UART_TX_WAIT_EN):
//   A MEM write to UART_DATA_ADDR waits in TX_WAIT until tx_ready_i.
//   After TX_TIMEOUT cycles without tx_ready_i the write is dropped, the
//   ack still pulses, and the sticky tx_drop flag is set (reset clears it).
//   Without the macro there is no TX_WAIT and tx_ready_i is ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   if_*              IF read request/ack/data (request held until ack)
//   mem_*             MEM request/ack/data (request held until ack)
//   stall_o           high while a request is pending and not yet acked
//   is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o
//                     one-cycle command toward ram1
//   ram1res_i         read data from ram1
//   tx_ready_i        UART transmitter empty (feature build only)
module ram1_bus_arbiter #(
    parameter int          ADDR_W         = 18,
    parameter int          DATA_W         = 16,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int          STARVE_MAX     = 4,
    parameter int          TX_TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stall_o,
    output logic              is_RAM1_o,
    output logic              is_UART_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              isread_o,
    output logic              iswrite_o,
    input  logic [DATA_W-1:0] ram1res_i,
    input  logic              tx_ready_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

`ifdef UART_TX_WAIT_EN
    localparam int TX_W = $clog2(TX_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, TX_WAIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  starve_cnt, cnt_n;
    logic              grant_mem, grant_if;
    logic              sel_mem;     // current transaction belongs to MEM
    logic              we_q;
    logic              uart_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              mem_is_uart;
    logic              starve_hit;

`ifdef UART_TX_WAIT_EN
    logic [TX_W-1:0]   tx_cnt;
    logic              tx_expire;
    logic              tx_drop;
    logic              unused_tx_drop;
    assign unused_tx_drop = tx_drop;
`else
    logic [31:0]       unused_tx;
    assign unused_tx = {tx_ready_i, 31'(TX_TIMEOUT)};
`endif

    // Only the low 16 address bits select the UART registers.
    assign mem_is_uart = (mem_addr_i[15:0] == UART_DATA_ADDR) ||
                         (mem_addr_i[15:0] == UART_STAT_ADDR);
    assign starve_hit  = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n     = state;
        grant_mem   = 1'b0;
        grant_if    = 1'b0;
        cnt_n       = starve_cnt;
`ifdef UART_TX_WAIT_EN
        tx_expire   = 1'b0;
`endif
        is_RAM1_o   = 1'b0;
        is_UART_o   = 1'b0;
        isread_o    = 1'b0;
        iswrite_o   = 1'b0;
        addr_o      = '0;
        data_o      = '0;
        if_ack_o    = 1'b0;
        mem_ack_o   = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req_i && !(if_req_i && starve_hit)) begin
                    grant_mem = 1'b1;
                    // With IF pending we only get here below STARVE_MAX,
                    // so the increment saturates by construction.
                    cnt_n     = if_req_i ? starve_cnt + 1'b1 : '0;
                    state_n   = ISSUE;
`ifdef UART_TX_WAIT_EN
                    if (mem_we_i && (mem_addr_i[15:0] == UART_DATA_ADDR))
                        state_n = TX_WAIT;
`endif
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                    cnt_n    = '0;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                is_RAM1_o = ~uart_q;
                is_UART_o = uart_q;
                isread_o  = ~we_q;
                iswrite_o = we_q;
                addr_o    = addr_q;
                data_o    = we_q ? wdata_q : '0;
                state_n   = CAPTURE;
            end
            CAPTURE: begin
                if_ack_o  = ~sel_mem;
                mem_ack_o = sel_mem;
                state_n   = IDLE;
            end
`ifdef UART_TX_WAIT_EN
            TX_WAIT: begin
                if (tx_ready_i) begin
                    state_n = ISSUE;
                end else if (tx_cnt == TX_W'(TX_TIMEOUT - 1)) begin
                    // Give up: skip the bus command but still ack.
                    state_n   = CAPTURE;
                    tx_expire = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt  <= '0;
            sel_mem     <= 1'b0;
            we_q        <= 1'b0;
            uart_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            starve_cnt <= cnt_n;
            if (grant_mem) begin
                sel_mem <= 1'b1;
                we_q    <= mem_we_i;
                uart_q  <= mem_is_uart;
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
            end else if (grant_if) begin
                sel_mem <= 1'b0;
                we_q    <= 1'b0;
                uart_q  <= 1'b0;
                addr_q  <= if_addr_i;
                wdata_q <= '0;
            end
            // ram1 presents read data from the negedge inside ISSUE, so the
            // word is taken on the ISSUE->CAPTURE edge and is valid with ack.
            if (state == ISSUE && !we_q) begin
                if (sel_mem) mem_rdata_q <= ram1res_i;
                else         if_rdata_q  <= ram1res_i;
            end
        end
    end

`ifdef UART_TX_WAIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt  <= '0;
            tx_drop <= 1'b0;
        end else begin
            tx_cnt <= (state == TX_WAIT) ? tx_cnt + 1'b1 : '0;
            if (tx_expire) tx_drop <= 1'b1;
        end
    end
`endif

    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign stall_o     = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
module tb_ram1_bus_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        is_ram1;
    logic        is_uart;
    logic [17:0] addr_o;
    logic [15:0] data_o;
    logic        isread;
    logic        iswrite;
    logic [15:0] ram1res;
    logic        tx_ready;

    ram1_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata),
        .stall_o(stall), .is_RAM1_o(is_ram1), .is_UART_o(is_uart),
        .addr_o(addr_o), .data_o(data_o), .isread_o(isread), .iswrite_o(iswrite),
        .ram1res_i(ram1res), .tx_ready_i(tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_reqs();
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    // Directed single-transaction vectors
    typedef struct {
        logic        port_mem;
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [15:0] res;
        logic        exp_uart;
        logic [15:0] exp_rdata;   // rdata of that port after the ack
    } vec_t;

    vec_t tbl[8];

    // Starts at a negedge with the arbiter idle, ends at the next idle negedge.
    task automatic run_vec(input int idx, input vec_t v);
        ram1res = v.res;
        if (v.port_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        chk1($sformatf("v%0d_ram1", idx), is_ram1, ~v.exp_uart);
        chk1($sformatf("v%0d_uart", idx), is_uart, v.exp_uart);
        chk1($sformatf("v%0d_rd", idx), isread, ~v.we);
        chk1($sformatf("v%0d_wr", idx), iswrite, v.we);
        chk($sformatf("v%0d_addr", idx), 32'(addr_o), 32'(v.addr));
        chk($sformatf("v%0d_data", idx), 32'(data_o), 32'(v.we ? v.wdata : 16'h0));
        chk1($sformatf("v%0d_stall_issue", idx), stall, 1'b1);
        @(negedge clk);
        chk1($sformatf("v%0d_if_ack", idx), if_ack, ~v.port_mem);
        chk1($sformatf("v%0d_mem_ack", idx), mem_ack, v.port_mem);
        chk1($sformatf("v%0d_bus_quiet", idx), is_ram1 | is_uart | isread | iswrite, 1'b0);
        chk1($sformatf("v%0d_stall_ack", idx), stall, 1'b0);
        chk($sformatf("v%0d_rdata", idx), 32'(v.port_mem ? mem_rdata : if_rdata), 32'(v.exp_rdata));
        clear_reqs();
        @(negedge clk);
    endtask

    // Reference model: a transaction timeline (age since grant) plus the
    // arbitration rules written directly from the priority/starvation policy.
    int          m_age;      // 0 free, 1 command cycle, 2 ack cycle
    logic        m_mem, m_we, m_uart;
    logic [17:0] m_addr;
    logic [15:0] m_wdata;
    int          m_starve;
    logic [15:0] m_if_rd, m_mem_rd;

    task automatic model_reset();
        m_age = 0; m_mem = 0; m_we = 0; m_uart = 0; m_addr = '0; m_wdata = '0;
        m_starve = 0; m_if_rd = '0; m_mem_rd = '0;
    endtask

    task automatic model_step();
        if (m_age == 1) begin
            if (!m_we) begin
                if (m_mem) m_mem_rd = ram1res;
                else       m_if_rd  = ram1res;
            end
            m_age = 2;
        end else if (m_age == 2) begin
            m_age = 0;
        end else begin
            if (if_req && (!mem_req || m_starve == STARVE_MAX)) begin
                m_mem = 0; m_we = 0; m_uart = 0; m_addr = if_addr; m_wdata = '0;
                m_starve = 0; m_age = 1;
            end else if (mem_req) begin
                m_mem = 1; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
                m_uart = (mem_addr[15:0] == 16'hBF00) || (mem_addr[15:0] == 16'hBF01);
                m_starve = if_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
                m_age = 1;
            end
        end
    endtask

    function automatic logic [17:0] rand_addr();
        logic [17:0] a;
        a = 18'($urandom);
        case ($urandom_range(3))
            0: a[15:0] = 16'hBF00;
            1: a[15:0] = 16'hBF01;
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c;
        logic seen_wr;
        logic e_iss, e_cap, e_if_ack, e_mem_ack, e_stall;

        tbl[0] = '{1'b0, 1'b0, 18'h00100, 16'h0000, 16'h1234, 1'b0, 16'h1234};
        tbl[1] = '{1'b0, 1'b0, 18'h0BF00, 16'h0000, 16'h5A5A, 1'b0, 16'h5A5A};
        tbl[2] = '{1'b1, 1'b0, 18'h0BF01, 16'h0000, 16'h0003, 1'b1, 16'h0003};
        tbl[3] = '{1'b1, 1'b0, 18'h2BF00, 16'h0000, 16'h00AA, 1'b1, 16'h00AA};
        tbl[4] = '{1'b1, 1'b1, 18'h08000, 16'hBEEF, 16'h1111, 1'b0, 16'h00AA};
        tbl[5] = '{1'b1, 1'b0, 18'h0BF02, 16'h0000, 16'h7777, 1'b0, 16'h7777};
        tbl[6] = '{1'b1, 1'b1, 18'h1BF01, 16'h0042, 16'h2222, 1'b1, 16'h7777};
        tbl[7] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};

        rst = 1'b0; clear_reqs(); tx_ready = 1'b1; ram1res = '0;
        #1;
        chk1("rst_ram1", is_ram1, 1'b0);
        chk1("rst_uart", is_uart, 1'b0);
        chk1("rst_rd", isread, 1'b0);
        chk1("rst_wr", iswrite, 1'b0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_mem_ack", mem_ack, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_addr", 32'(addr_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_if_rdata", 32'(if_rdata), 32'h0);
        chk("rst_mem_rdata", 32'(mem_rdata), 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Simultaneous IF read and MEM write: MEM first, IF right after.
        ram1res = 16'hC0DE;
        if_req = 1'b1; if_addr = 18'h00100;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h08000; mem_wdata = 16'hBEEF;
        @(negedge clk);
        chk1("sim_mem_wr", iswrite, 1'b1);
        chk("sim_mem_data", 32'(data_o), 32'hBEEF);
        chk1("sim_stall1", stall, 1'b1);
        @(negedge clk);
        chk1("sim_mem_ack", mem_ack, 1'b1);
        chk1("sim_no_if_ack", if_ack, 1'b0);
        chk1("sim_stall_if_wait", stall, 1'b1);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk1("sim_gap_quiet", is_ram1 | isread | iswrite, 1'b0);
        chk1("sim_stall_idle", stall, 1'b1);
        @(negedge clk);
        chk1("sim_if_rd", isread, 1'b1);
        chk1("sim_if_ram1", is_ram1, 1'b1);
        chk("sim_if_addr", 32'(addr_o), 32'h00100);
        @(negedge clk);
        chk1("sim_if_ack", if_ack, 1'b1);
        chk("sim_if_rdata", 32'(if_rdata), 32'hC0DE);
        chk("sim_mem_rdata_held", 32'(mem_rdata), 32'hFFFF & 32'h7777);
        clear_reqs();
        @(negedge clk);

        // Starvation: MEM held continuously, IF pending -> M M M M I M
        mem_req = 1'b1; mem_addr = 18'h00200; if_req = 1'b1; if_addr = 18'h00300;
        n = 0;
        for (c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (if_ack || mem_ack) begin
                chk1($sformatf("starve_grant%0d_is_if", n), if_ack, (n == 4));
                if (if_ack) if_req = 1'b0;
                n++;
            end
        end
        if (n < 6) begin
            checks++; errors++;
            $display("FAIL starve_timeout: got %0d acks want 6", n);
        end
        clear_reqs();
        @(negedge clk);

        // Reset pulled during the command cycle
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h01234; mem_wdata = 16'hCAFE;
        @(negedge clk);
        chk1("rmid_wr_before", iswrite, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk1("rmid_wr_drop", iswrite, 1'b0);
        chk1("rmid_ram1_drop", is_ram1, 1'b0);
        chk1("rmid_ack", mem_ack, 1'b0);
        chk("rmid_if_rdata", 32'(if_rdata), 32'h0);
        @(negedge clk);
        chk1("rmid_ack_in_rst", mem_ack, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("rmid_rearb_wr", iswrite, 1'b1);
        chk("rmid_rearb_addr", 32'(addr_o), 32'h01234);
        @(negedge clk);
        chk1("rmid_rearb_ack", mem_ack, 1'b1);
        clear_reqs();
        @(negedge clk);

`ifdef UART_TX_WAIT_EN
        tx_ready = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h0BF00; mem_wdata = 16'h0041;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("txw_no_wr", iswrite, 1'b0);
            chk1("txw_stall", stall, 1'b1);
            chk1("txw_no_ack", mem_ack, 1'b0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk1("txw_wr", iswrite, 1'b1);
        chk1("txw_uart", is_uart, 1'b1);
        chk("txw_data", 32'(data_o), 32'h0041);
        @(negedge clk);
        chk1("txw_ack", mem_ack, 1'b1);
        chk1("txw_no_drop", dut.tx_drop, 1'b0);
        clear_reqs();
        @(negedge clk);

        tx_ready = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h0BF00; mem_wdata = 16'h0042;
        n = 0; seen_wr = 1'b0;
        for (c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (iswrite) seen_wr = 1'b1;
            if (mem_ack) begin n = c; break; end
        end
        chk("txto_ack_cycle", 32'(n), 32'd1024);
        chk1("txto_no_wr", seen_wr, 1'b0);
        chk1("txto_drop", dut.tx_drop, 1'b1);
        clear_reqs(); tx_ready = 1'b1;
        @(negedge clk);
`else
        // tx_ready is ignored: UART data write issues straight away
        tx_ready = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h0BF00; mem_wdata = 16'h0041;
        @(negedge clk);
        chk1("txi_wr", iswrite, 1'b1);
        chk1("txi_uart", is_uart, 1'b1);
        @(negedge clk);
        chk1("txi_ack", mem_ack, 1'b1);
        clear_reqs(); tx_ready = 1'b1;
        @(negedge clk);
`endif

        // Randomized traffic against the reference model
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            e_iss     = (m_age == 1);
            e_cap     = (m_age == 2);
            e_if_ack  = e_cap & ~m_mem;
            e_mem_ack = e_cap & m_mem;
            e_stall   = (if_req & ~e_if_ack) | (mem_req & ~e_mem_ack);
            chk("rnd_flags", 32'({is_ram1, is_uart, isread, iswrite, if_ack, mem_ack, stall}),
                32'({e_iss & ~m_uart, e_iss & m_uart, e_iss & ~m_we, e_iss & m_we,
                     e_if_ack, e_mem_ack, e_stall}));
            chk("rnd_addr", 32'(addr_o), 32'(e_iss ? m_addr : 18'h0));
            chk("rnd_data", 32'(data_o), 32'((e_iss && m_we) ? m_wdata : 16'h0));
            chk("rnd_if_rdata", 32'(if_rdata), 32'(m_if_rd));
            chk("rnd_mem_rdata", 32'(mem_rdata), 32'(m_mem_rd));

            ram1res = 16'($urandom);
            if (if_req) begin
                if (e_if_ack) if_req = 1'b0;
                else if (!(m_age != 0 && !m_mem) && $urandom_range(15) == 0) if_req = 1'b0;
            end else if ($urandom_range(1) == 1) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
            if (mem_req) begin
                if (e_mem_ack) mem_req = 1'b0;
                else if (!(m_age != 0 && m_mem) && $urandom_range(15) == 0) mem_req = 1'b0;
            end else if ($urandom_range(1) == 1) begin
                mem_req = 1'b1; mem_we = 1'($urandom_range(1));
                mem_addr = rand_addr(); mem_wdata = 16'($urandom);
`ifdef UART_TX_WAIT_EN
                if (mem_we && mem_addr[15:0] == 16'hBF00) mem_addr[15:0] = 16'hBF01;
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
